// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-decode helpers for the load/store sequencer.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:        mis = a[0];
            2'b10, 2'b11: mis = (a != 2'b00);
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] be_decode(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_replicate(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane selection and sign/zero extension of a loaded memory word.
module load_extend (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] lane_s;

    // Shift the addressed byte lane down, then extend by access size.
    always_comb begin
        lane_s = word >> {addr_lo, 3'b000};
        case (funct3[1:0])
            2'b00:   result = funct3[2] ? {24'h000000, lane_s[7:0]}
                                        : {{24{lane_s[7]}}, lane_s[7:0]};
            2'b01:   result = funct3[2] ? {16'h0000, lane_s[15:0]}
                                        : {{16{lane_s[15]}}, lane_s[15:0]};
            default: result = lane_s;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: stalls the core while one access runs against a handshaked,
// variable-latency data memory, and returns the extended load result or a fault.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_r;
    logic             is_store_r;
    logic [2:0]       funct3_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             fault_r;
    logic [31:0]      rdata_r;

    logic             is_store_s;
    logic             mem_op_s;
    logic             legal_s;
    logic [31:0]      ext_s;

    // Decode the instruction currently presented by the core.
    always_comb begin
        is_store_s = (i_opcode == OP_STORE);
        mem_op_s   = i_valid & ((i_opcode == OP_LOAD) | is_store_s);
        legal_s    = f3_legal(is_store_s, i_funct3) & ~is_misaligned(i_funct3, i_addr[1:0]);
    end

    load_extend u_load_extend (
        .funct3  (funct3_r),
        .addr_lo (addr_r[1:0]),
        .word    (i_mem_rdata),
        .result  (ext_s)
    );

    // Sequencer FSM with registered completion outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            is_store_r <= 1'b0;
            funct3_r   <= 3'b000;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            cnt_r      <= '0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= '0;
                    rdata_r <= 32'h0000_0000;
                    if (mem_op_s) begin
                        is_store_r <= is_store_s;
                        funct3_r   <= i_funct3;
                        addr_r     <= i_addr;
                        wdata_r    <= i_wdata;
                        if (legal_s) begin
                            state_r <= ST_WAIT;
                            done_r  <= 1'b0;
                            fault_r <= 1'b0;
                        end else begin
                            state_r <= ST_RESP;
                            done_r  <= 1'b1;
                            fault_r <= 1'b1;
                        end
                    end else begin
                        done_r  <= 1'b0;
                        fault_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (i_mem_ack) begin
                        state_r <= ST_RESP;
                        done_r  <= 1'b1;
                        fault_r <= 1'b0;
                        rdata_r <= is_store_r ? 32'h0000_0000 : ext_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_RESP;
                        done_r  <= 1'b1;
                        fault_r <= 1'b1;
                        rdata_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Memory-side outputs are decoded purely from registered state and captured fields.
    always_comb begin
        if (state_r == ST_WAIT) begin
            o_mem_req   = 1'b1;
            o_mem_we    = is_store_r;
            o_mem_addr  = {addr_r[31:2], 2'b00};
            o_mem_be    = be_decode(funct3_r, addr_r[1:0]);
            o_mem_wdata = is_store_r ? wdata_replicate(funct3_r, wdata_r) : 32'h0000_0000;
        end else begin
            o_mem_req   = 1'b0;
            o_mem_we    = 1'b0;
            o_mem_addr  = 32'h0000_0000;
            o_mem_be    = 4'b0000;
            o_mem_wdata = 32'h0000_0000;
        end
    end

    assign o_stall = ((state_r == ST_IDLE) & mem_op_s) | (state_r == ST_WAIT);
    assign o_done  = done_r;
    assign o_fault = fault_r;
    assign o_rdata = rdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl, built with TIMEOUT=4.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_stall     (stall),
        .o_done      (done),
        .o_fault     (fault),
        .o_rdata     (rdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task tick;
        @(negedge clk);
    endtask

    task present(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = d;
    endtask

    task idle_inputs;
        valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    endtask

    task test_reset;
        #1;
        total++; if ({stall, done, fault, mem_req, mem_we} !== 5'b00000) begin bad++; $display("FAIL reset_flags: got %b want 00000", {stall, done, fault, mem_req, mem_we}); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        total++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin bad++; $display("FAIL reset_mem: got %h %b %h want zeros", mem_addr, mem_be, mem_wdata); end
    endtask

    task test_lb;
        present(LD, 3'b000, 32'h0000_1003, 32'hDEAD_BEEF); #1;
        total++; if ({stall, mem_req} !== 2'b10) begin bad++; $display("FAIL lb_c0: stall/req got %b want 10", {stall, mem_req}); end
        tick; idle_inputs; #1;
        total++; if ({mem_req, mem_we, stall, done} !== 4'b1010) begin bad++; $display("FAIL lb_c1_flags: got %b want 1010", {mem_req, mem_we, stall, done}); end
        total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL lb_addr: got %h want 00001000", mem_addr); end
        total++; if (mem_be !== 4'b1000) begin bad++; $display("FAIL lb_be: got %b want 1000", mem_be); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL lb_wdata: got %h want 0", mem_wdata); end
        tick; #1;
        total++; if ({stall, mem_req, done} !== 3'b110) begin bad++; $display("FAIL lb_c2: got %b want 110", {stall, mem_req, done}); end
        tick; mem_ack = 1'b1; mem_rdata = 32'h80FF_1234; #1;
        total++; if ({stall, mem_req, done} !== 3'b110) begin bad++; $display("FAIL lb_c3: got %b want 110", {stall, mem_req, done}); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, fault, stall, mem_req} !== 4'b1000) begin bad++; $display("FAIL lb_c4_flags: got %b want 1000", {done, fault, stall, mem_req}); end
        total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", rdata); end
        tick; #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL lb_done_pulse: got %b want 0", done); end
    endtask

    task test_lhu;
        present(LD, 3'b101, 32'h0000_2002, 32'h0); tick; idle_inputs;
        mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000; #1;
        total++; if ({mem_req, mem_be} !== 5'b11100) begin bad++; $display("FAIL lhu_req_be: got %b want 11100", {mem_req, mem_be}); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, fault} !== 2'b10) begin bad++; $display("FAIL lhu_done: got %b want 10", {done, fault}); end
        total++; if (rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_rdata: got %h want 0000beef", rdata); end
        tick;
    endtask

    task test_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_addr);
        present(ST, f3, a, d); tick; idle_inputs;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL st_req_we: got %b want 11", {mem_req, mem_we}); end
        total++; if (mem_be !== exp_be) begin bad++; $display("FAIL st_be: got %b want %b", mem_be, exp_be); end
        total++; if (mem_wdata !== exp_wd) begin bad++; $display("FAIL st_wdata: got %h want %h", mem_wdata, exp_wd); end
        total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL st_addr: got %h want %h", mem_addr, exp_addr); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, fault, rdata} !== {2'b10, 32'h0}) begin bad++; $display("FAIL st_done: got %b %b %h want 1 0 0", done, fault, rdata); end
        tick;
    endtask

    task test_faults;
        logic [6:0]  f_op [4] = '{LD, LD, ST, LD};
        logic [2:0]  f_f3 [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
        logic [31:0] f_ad [4] = '{32'h4002, 32'h5001, 32'h5000, 32'h5000};
        for (int i = 0; i < 4; i++) begin
            present(f_op[i], f_f3[i], f_ad[i], 32'h1234_5678); #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL fault%0d_stall: got %b want 1", i, stall); end
            tick; idle_inputs; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
            total++; if ({mem_req, done, fault, stall} !== 4'b0110) begin bad++; $display("FAIL fault%0d_flags: got %b want 0110", i, {mem_req, done, fault, stall}); end
            total++; if (rdata !== 32'h0) begin bad++; $display("FAIL fault%0d_rdata: got %h want 0", i, rdata); end
            tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
            total++; if ({done, mem_req} !== 2'b00) begin bad++; $display("FAIL fault%0d_after: got %b want 00", i, {done, mem_req}); end
        end
    endtask

    task test_ignore;
        present(7'b0110011, 3'b010, 32'h0000_6000, 32'h0); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ignore_stall: got %b want 0", stall); end
        tick; idle_inputs; #1;
        total++; if ({mem_req, done} !== 2'b00) begin bad++; $display("FAIL ignore_next: got %b want 00", {mem_req, done}); end
    endtask

    task test_timeout;
        present(LD, 3'b010, 32'h0000_6000, 32'h0); tick; idle_inputs;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++; if ({mem_req, done, stall} !== 3'b101) begin bad++; $display("FAIL timeout_wait%0d: got %b want 101", c, {mem_req, done, stall}); end
            tick;
        end
        #1;
        total++; if ({done, fault, mem_req, stall} !== 4'b1100) begin bad++; $display("FAIL timeout_flags: got %b want 1100", {done, fault, mem_req, stall}); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata: got %h want 0", rdata); end
        tick;
    endtask

    task test_ack_last;
        present(LD, 3'b010, 32'h0000_6004, 32'h0); tick; idle_inputs;
        tick; tick; tick;
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344; #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL acklast_req: got %b want 1", mem_req); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, fault} !== 2'b10) begin bad++; $display("FAIL acklast_flags: got %b want 10", {done, fault}); end
        total++; if (rdata !== 32'h1122_3344) begin bad++; $display("FAIL acklast_rdata: got %h want 11223344", rdata); end
        tick;
    endtask

    task test_back_to_back;
        present(LD, 3'b010, 32'h0000_8000, 32'h0); tick; idle_inputs;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick; mem_ack = 1'b0; mem_rdata = 32'h0;
        present(LD, 3'b100, 32'h0000_8001, 32'h0); #1;
        total++; if ({done, stall} !== 2'b10) begin bad++; $display("FAIL b2b_resp: got %b want 10", {done, stall}); end
        total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rdata_a: got %h want cafef00d", rdata); end
        tick; #1;
        total++; if ({stall, mem_req, done} !== 3'b100) begin bad++; $display("FAIL b2b_accept: got %b want 100", {stall, mem_req, done}); end
        tick; idle_inputs; mem_ack = 1'b1; mem_rdata = 32'h0000_9A00; #1;
        total++; if ({mem_req, mem_be} !== 5'b10010) begin bad++; $display("FAIL b2b_req_be: got %b want 10010", {mem_req, mem_be}); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, rdata} !== {1'b1, 32'h0000_009A}) begin bad++; $display("FAIL b2b_rdata_b: got %b %h want 1 0000009a", done, rdata); end
        tick;
    endtask

    task test_async_reset;
        present(LD, 3'b010, 32'h0000_7004, 32'h0); tick; idle_inputs; #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL arst_pre_req: got %b want 1", mem_req); end
        #2; rst_n = 1'b0; #1;
        total++; if ({mem_req, stall, done, fault} !== 4'b0000) begin bad++; $display("FAIL arst_flags: got %b want 0000", {mem_req, stall, done, fault}); end
        total++; if ({mem_addr, mem_be} !== 36'h0) begin bad++; $display("FAIL arst_mem: got %h %b want zeros", mem_addr, mem_be); end
        tick; rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, mem_req, stall} !== 3'b000) begin bad++; $display("FAIL arst_idle_ack: got %b want 000", {done, mem_req, stall}); end
        present(LD, 3'b010, 32'h0000_7008, 32'h0); tick; idle_inputs;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A; #1;
        total++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_7008}) begin bad++; $display("FAIL arst_new_req: got %b %h want 1 00007008", mem_req, mem_addr); end
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        total++; if ({done, fault, rdata} !== {2'b10, 32'h5A5A_5A5A}) begin bad++; $display("FAIL arst_new_done: got %b %b %h want 1 0 5a5a5a5a", done, fault, rdata); end
        tick;
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        idle_inputs;
        tick; tick;
        test_reset;
        tick; rst_n = 1'b1;
        tick;
        test_lb;
        test_lhu;
        test_store(3'b000, 32'h0000_3001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, 32'h0000_3000);
        test_store(3'b001, 32'h0000_3002, 32'h0000_C0DE, 4'b1100, 32'hC0DE_C0DE, 32'h0000_3000);
        test_store(3'b010, 32'h0000_3004, 32'h8765_4321, 4'b1111, 32'h8765_4321, 32'h0000_3004);
        test_faults;
        test_ignore;
        test_timeout;
        test_ack_last;
        test_back_to_back;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the single-cycle core's execute stage and a handshaked, variable-latency data memory. It accepts one load or store per instruction and stalls the core until the memory acknowledges. It generates word-aligned addresses, byte enables and lane-replicated store data, and returns the byte/halfword/word-extracted, sign- or zero-extended load result. It also detects misaligned accesses and memory timeouts.

## Interface
- `TIMEOUT`, default 255: maximum cycles in WAIT without `i_mem_ack` before a fault; legal range 1..1023.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: the current instruction is presented by the core.
- `i_opcode` input 7: instruction opcode.
- `i_funct3` input 3: access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `i_addr` input 32: effective byte address.
- `i_wdata` input 32: store data (rs2).
- `o_stall` output 1: core must hold PC and writeback.
- `o_done` output 1: one-cycle completion pulse.
- `o_fault` output 1: qualifies `o_done`; misaligned, illegal funct3 or timeout.
- `o_rdata` output 32: extended load result; valid with `o_done`.
- `o_mem_req` output 1: memory request, held until ack.
- `o_mem_we` output 1: 1 = store.
- `o_mem_addr` output 32: `{addr[31:2],2'b00}`.
- `o_mem_be` output 4: byte enables.
- `o_mem_wdata` output 32: lane-replicated store data.
- `i_mem_ack` input 1: memory completion, sampled on the `i_clk` edge.
- `i_mem_rdata` input 32: read word; valid with ack.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: all registered outputs and captured fields are 0. Async assertion drops `o_mem_req` immediately, mid-transaction included, and returns the FSM to IDLE.
- IDLE: a request is a memory op when `i_valid` is set and `i_opcode` is 0000011 (load) or 0100011 (store). Any other opcode is ignored and leaves `o_stall`=0.
  - On a memory op, capture opcode, funct3, addr and wdata.
  - If the access is legal, go to WAIT. If it is illegal, go to RESP with the fault flag set.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
- Misaligned accesses:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
- WAIT: `o_mem_req`=1 and the memory outputs are driven from captured fields.
  - On ack, latch the extracted read data (loads only) and go to RESP.
  - The timeout counter resets to 0 on WAIT entry and increments each WAIT cycle without ack. When it reaches TIMEOUT-1 with no ack, go to RESP with fault set and rdata=0. Ack in that same cycle wins.
- RESP: `o_done`=1 and `o_fault` reflects the fault flag. Go to IDLE.
- `i_mem_ack` is ignored in IDLE and RESP.
- `i_valid` and the other inputs are ignored while in WAIT or RESP; captured values are used.
- `o_stall` is combinational: (IDLE & memory op) | WAIT. It is 0 in RESP, so the core commits and advances on the `o_done` cycle.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata passed through.
- For loads, `o_mem_be` uses the same pattern as stores and `o_mem_wdata` is 0.
- Load extract:
  - lane = rdata >> (8·addr[1:0]).
  - funct3[1:0] selects size: 00 byte, 01 half, 1x word.
  - funct3[2]=0 sign-extends from bit 7 or 15; funct3[2]=1 zero-extends.
- `o_rdata` is 0 for stores and for faults.

## Timing
- Minimum latency: accept in cycle 0 (IDLE) → `o_mem_req` in cycle 1 → ack in cycle 1 → `o_done` in cycle 2.
- Each additional cycle of memory wait adds one cycle of latency.
- A misaligned access gives `o_done`+`o_fault` in cycle 1 with no memory request.
- A timeout gives `o_done` in the cycle after the TIMEOUT-th WAIT cycle.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP. Throughput is one access per 3 cycles at zero wait.
- `o_rdata`, `o_done` and `o_fault` are registered. Memory-side outputs are registered, or decoded from registered fields only.

## Structure
- Package `lsu_pkg`: opcode constants (LOAD, STORE), funct3 encodings, state enum `lsu_state_t`, and the counter width function clog2(TIMEOUT+1).
- Sub-module `load_extend`: combinational lane shift plus sign/zero extension. It takes funct3, addr[1:0] and the 32-bit word, and returns the 32-bit result.

## Test plan
- LB: addr 0x1003, mem word 0x80FF_1234, ack after 2 wait cycles → `o_mem_addr` 0x1000, be 1000; `o_rdata` 0xFFFF_FF80; `o_done` in cycle 4; `o_stall` high in cycles 0–3.
- LHU: addr 0x2002, word 0xBEEF_0000, ack immediate → `o_rdata` 0x0000_BEEF, `o_done` in cycle 2, `o_fault`=0.
- SB: addr 0x3001, wdata 0x1234_56AB → we=1, be 0010, `o_mem_wdata` 0xABAB_ABAB.
- SH: addr 0x3002, wdata 0x0000_C0DE → be 1100, `o_mem_wdata` 0xC0DE_C0DE.
- LW at 0x4002 → no `o_mem_req`; `o_done`=`o_fault`=1 in cycle 1; `o_rdata` 0.
- TIMEOUT=4, no ack → `o_fault`; then a request with `i_rst_n` pulsed low during WAIT → `o_mem_req` drops asynchronously, FSM in IDLE, outputs 0.
